// File: rtl/player_collision_checker.sv
// Sprite-vs-level collision checker: walks the four sprite corners through the
// safe-zone query port and reports one hit verdict plus a saturating hit count.
module player_collision_checker #(
   parameter int SCREEN_WIDTH  = 400,
   parameter int SCREEN_HEIGHT = 600,
   parameter int PLAYER_SIZE   = 20,
   localparam int XW = $clog2(SCREEN_WIDTH),
   localparam int YW = $clog2(SCREEN_HEIGHT)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          i_check,
   input  logic [XW-1:0] i_px,
   input  logic [YW-1:0] i_py,
   input  logic          i_clear,
   input  logic          i_zone_rdy,
   input  logic          i_is_safe,
   output logic          o_q_en,
   output logic [XW-1:0] o_q_x,
   output logic [YW-1:0] o_q_y,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_hit,
   output logic [7:0]    o_hit_count
);

   // state    | meaning
   // IDLE     | waiting for i_check
   // WAIT_RDY | request latched, safe_zone still regenerating
   // CHECK    | querying corner k (0 TL, 1 TR, 2 BL, 3 BR)
   // DONE     | verdict strobe, hit counter update
   typedef enum logic [1:0] {IDLE, WAIT_RDY, CHECK, DONE} state_t;

   localparam logic [XW:0] X_MAX = (XW+1)'(SCREEN_WIDTH - 1);
   localparam logic [YW:0] Y_MAX = (YW+1)'(SCREEN_HEIGHT - 1);
   localparam logic [XW:0] X_EXT = (XW+1)'(PLAYER_SIZE - 1);
   localparam logic [YW:0] Y_EXT = (YW+1)'(PLAYER_SIZE - 1);

   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [XW-1:0] px_q, px_d;
   logic [YW-1:0] py_q, py_d;
   logic          hit_q, hit_d;
   logic [7:0]    cnt_q, cnt_d;

   logic [XW:0]   x_l_w, x_r_w;
   logic [YW:0]   y_t_w, y_b_w;
   logic [XW-1:0] x_l, x_r;
   logic [YW-1:0] y_t, y_b;

   // Sums carry one extra bit so the clamp sees true overflow past the screen edge.
   always_comb begin
      x_l_w = {1'b0, px_q};
      x_r_w = x_l_w + X_EXT;
      y_t_w = {1'b0, py_q};
      y_b_w = y_t_w + Y_EXT;
      x_l   = (x_l_w > X_MAX) ? X_MAX[XW-1:0] : x_l_w[XW-1:0];
      x_r   = (x_r_w > X_MAX) ? X_MAX[XW-1:0] : x_r_w[XW-1:0];
      y_t   = (y_t_w > Y_MAX) ? Y_MAX[YW-1:0] : y_t_w[YW-1:0];
      y_b   = (y_b_w > Y_MAX) ? Y_MAX[YW-1:0] : y_b_w[YW-1:0];
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      px_d    = px_q;
      py_d    = py_q;
      hit_d   = hit_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (i_check) begin
               px_d    = i_px;
               py_d    = i_py;
               k_d     = 2'd0;
               state_d = i_zone_rdy ? CHECK : WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            k_d = 2'd0;
            if (i_zone_rdy) state_d = CHECK;
         end
         CHECK: begin
            // A level regeneration invalidates the answer, so restart from TL.
            if (!i_zone_rdy) begin
               k_d     = 2'd0;
               state_d = WAIT_RDY;
            end else if (!i_is_safe) begin
               hit_d   = 1'b1;
               state_d = DONE;
            end else if (k_q == 2'd3) begin
               hit_d   = 1'b0;
               state_d = DONE;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (hit_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
      if (i_clear) cnt_d = (state_q == DONE && hit_q) ? 8'd1 : 8'd0;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
         px_q    <= '0;
         py_q    <= '0;
         hit_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         px_q    <= px_d;
         py_q    <= py_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      o_q_en      = (state_q == CHECK);
      o_q_x       = o_q_en ? (k_q[0] ? x_r : x_l) : '0;
      o_q_y       = o_q_en ? (k_q[1] ? y_b : y_t) : '0;
      o_busy      = (state_q != IDLE);
      o_done      = (state_q == DONE);
      o_hit       = hit_q;
      o_hit_count = cnt_q;
   end

endmodule

// File: doc/player_collision_checker.md
# player_collision_checker

Checks whether the player sprite overlaps an unsafe block of the generated level. The block sits directly downstream of `safe_zone`: on a request it walks the four sprite corners through the safe-zone query port, one per cycle, and reports a single hit/no-hit verdict. It also keeps a saturating hit counter for the game-state logic. Top level muxes `safe_zone` `i_x`/`i_y` to this block's query outputs whenever `o_q_en` is high.

## Interface
- SCREEN_WIDTH, 400, screen width in pixels
- SCREEN_HEIGHT, 600, screen height in pixels
- PLAYER_SIZE, 20, sprite edge length in pixels (square sprite, ≥1)
- XW / YW (derived), $clog2(SCREEN_WIDTH) / $clog2(SCREEN_HEIGHT)

- clk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- i_check  in  1  request pulse; samples i_px/i_py
- i_px  in  XW  sprite top-left x
- i_py  in  YW  sprite top-left y
- i_clear  in  1  clears hit counter
- i_zone_rdy  in  1  `safe_zone` `o_rdy`
- i_is_safe  in  1  `safe_zone` `o_is_safe` (combinational from query)
- o_q_en  out  1  query port owned by this block
- o_q_x  out  XW  query x
- o_q_y  out  YW  query y
- o_busy  out  1  check in progress
- o_done  out  1  one-cycle verdict strobe
- o_hit  out  1  verdict; valid with o_done, held until next o_done
- o_hit_count  out  8  saturating count of hit verdicts

## Operation
- States: IDLE, WAIT_RDY, CHECK, DONE. 2-bit corner counter `k` (0 TL, 1 TR, 2 BL, 3 BR).
- IDLE: on i_check latch px/py, k←0; go CHECK if i_zone_rdy else WAIT_RDY. i_check in any other state ignored.
- WAIT_RDY: stay until i_zone_rdy=1, then CHECK with k=0.
- CHECK: o_q_en=1, drive corner k. At the clock edge sample i_is_safe:
  - unsafe → hit_flag←1, go DONE (early exit).
  - safe and k=3 → hit_flag←0, go DONE.
  - safe and k<3 → k←k+1.
  - i_zone_rdy=0 (level regeneration started) → abort: k←0, go WAIT_RDY; i_is_safe ignored that cycle.
- DONE: one cycle; o_done=1, o_hit←hit_flag, o_hit_count incremented if hit (saturate at 255); go IDLE.
- Corner coordinates: left x=px, right x=min(px+PLAYER_SIZE-1, SCREEN_WIDTH-1); top y=py, bottom y=min(py+PLAYER_SIZE-1, SCREEN_HEIGHT-1). Sums computed at XW+1/YW+1 bits before clamp; px ≥ SCREEN_WIDTH is clamped to SCREEN_WIDTH-1 too (same for y).
- o_q_x/o_q_y = 0 and o_q_en=0 outside CHECK.
- i_clear: o_hit_count←0; if coincident with a DONE hit, result is 1 (clear, then count).
- o_busy = (state != IDLE).

## Timing
- Reset: state IDLE, k=0; o_busy, o_done, o_hit, o_q_en = 0; o_q_x, o_q_y = 0; o_hit_count = 0.
- All-safe, rdy high: i_check sampled at edge E0; corners queried in cycles E0–E1 … E3–E4; o_done high E4–E5. Latency 4 cycles from request edge to o_done; next i_check accepted at E5.
- Hit at corner k: o_done high E(k+1)–E(k+2).
- WAIT_RDY adds one cycle per cycle i_zone_rdy is low; abort restarts from TL, full 4 queries again.
- i_is_safe sampled in the same cycle the query is driven (no read latency).

## Test plan
- Level all safe, i_px=100, i_py=200, rdy=1 → queries (100,200),(119,200),(100,219),(119,219) on consecutive cycles; o_done 4 cycles after i_check, o_hit=0, count 0.
- Block containing (119,219) unsafe only → 4 queries, o_hit=1, count 1; then unsafe at TL → o_done after 1 cycle, count 2, no TR query seen.
- i_px=390, i_py=590 → right/bottom clamp to 399/599; queries (390,590),(399,590),(390,599),(399,599).
- i_check with rdy=0 for 3 cycles → o_busy=1, o_q_en=0 for 3 cycles, then normal 4-query sequence; rdy drops after 2 queries → restart at TL, verdict correct.
- 300 hit checks → o_hit_count saturates at 255; i_clear coincident with hit → 1; i_check while busy ignored (single o_done).
- Reset asserted mid-CHECK → next cycle all outputs at reset values, no o_done.
